// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
`timescale 1ns/1ps
package fetch_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int PC_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [PC_W-1:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of fetched {instr, pc} words with a registered head that
// holds its last value once the FIFO drains.
`timescale 1ns/1ps
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain_s;
  logic [W-1:0]  head_q, head_d;
  logic          do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  // Pointer/count update; head is reloaded from whichever entry will be first next cycle.
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
    remain_s  = count_q - CW'(do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = ptr_inc(wr_ptr_q);
      else wr_ptr_d = wr_ptr_q;
      if (do_pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
      else rd_ptr_d = rd_ptr_q;
      count_d = remain_s + CW'(do_push_s);
      if (remain_s != '0) head_d = mem_q[rd_ptr_d];
      else if (do_push_s) head_d = push_data_i;
      else head_d = head_q;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (do_push_s && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read at a time, buffered
// results handed to decode with valid/ready, flush discards everything.
`timescale 1ns/1ps
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [31:0]       id_pc,
  input  logic              id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = DATA_W + PC_W;

  fetch_state_e  state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_s;
  logic [W-1:0]  head_s;
  logic          busy_s, credit_s, push_s, pop_s;

  assign busy_s   = (state_q != IDLE);
  // The in-flight request reserves a buffer slot, so the FIFO can never overflow.
  assign credit_s = ({1'b0, count_s} + (CW + 1)'(busy_s)) < (CW + 1)'(DEPTH);
  assign pc_ready = (state_q == IDLE) && credit_s && !flush && reset;
  assign imem_req = (state_q == REQ);
  assign imem_addr = req_pc_q[ADDR_W-1:0];
  assign push_s   = (state_q == WAIT) && imem_rvalid && !flush;
  assign pop_s    = id_valid && id_ready;

  // Next-state logic for the request handshake.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IDLE: begin
        if (pc_valid && pc_ready) begin
          state_d  = REQ;
          req_pc_d = pc_in;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (imem_gnt) state_d = flush ? DRAIN : WAIT;
        else if (flush) state_d = IDLE;
        else state_d = REQ;
      end
      WAIT: begin
        if (imem_rvalid) state_d = IDLE;
        else if (flush) state_d = DRAIN;
        else state_d = WAIT;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = IDLE;
        else state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and captured request PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_buffer (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (flush),
    .push_i      (push_s),
    .push_data_i ({imem_rdata, req_pc_q}),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .head_o      (head_s)
  );

  assign id_valid = (count_s != '0);
  assign id_instr = head_s[W-1:PC_W];
  assign id_pc    = head_s[PC_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model
// compared against the DUT on every cycle.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset, pc_valid, imem_gnt, imem_rvalid, flush, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_ready, imem_req, id_valid;
  logic [11:0] imem_addr;
  logic [31:0] id_instr, id_pc;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  fetch_stage #(.ADDR_W(12), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .flush(flush), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready)
  );

  always #5 clock = ~clock;

  // Reference model: an outstanding-request record plus a queue of fetched entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  bit          m_out = 1'b0, m_gnt = 1'b0, m_disc = 1'b0;
  bit          m_acc, m_pop;
  logic [31:0] m_req_pc = 32'd0, m_last_instr = 32'd0, m_last_pc = 32'd0;

  function automatic bit exp_pc_ready();
    return (reset === 1'b1) && (flush === 1'b0) && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock);
    if (reset !== 1'b1) begin
      m_q.delete();
      m_out = 1'b0; m_gnt = 1'b0; m_disc = 1'b0;
      m_req_pc = 32'd0; m_last_instr = 32'd0; m_last_pc = 32'd0;
    end else begin
      m_acc = exp_pc_ready() && pc_valid;
      m_pop = (m_q.size() != 0) && id_ready;
      if (flush) begin
        if (m_out && !m_gnt) begin
          if (imem_gnt) begin m_gnt = 1'b1; m_disc = 1'b1; end
          else m_out = 1'b0;
        end else if (m_out) begin
          if (imem_rvalid) m_out = 1'b0;
          else m_disc = 1'b1;
        end
        m_q.delete();
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_out && !m_gnt) begin
          if (imem_gnt) m_gnt = 1'b1;
        end else if (m_out && imem_rvalid) begin
          if (!m_disc) begin
            m_e.instr = imem_rdata;
            m_e.pc    = m_req_pc;
            m_q.push_back(m_e);
          end
          m_out = 1'b0;
        end
        if (m_acc) begin
          m_out = 1'b1; m_gnt = 1'b0; m_disc = 1'b0; m_req_pc = pc_in;
        end
      end
      if (m_q.size() != 0) begin
        m_last_instr = m_q[0].instr;
        m_last_pc    = m_q[0].pc;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("pc_ready",  64'(pc_ready),  64'(exp_pc_ready()));
      chk("imem_req",  64'(imem_req),  64'(m_out && !m_gnt));
      chk("imem_addr", 64'(imem_addr), 64'(m_req_pc[11:0]));
      chk("id_valid",  64'(id_valid),  64'(m_q.size() != 0));
      chk("id_instr",  64'(id_instr),  64'(m_last_instr));
      chk("id_pc",     64'(id_pc),     64'(m_last_pc));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
    pc_in = pc; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    cyc();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pc_valid = 1'b1; imem_gnt = 1'b1; pc_in = 32'h7;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; flush = 1'b0; id_ready = 1'b0;
    cyc();
    cmp_en = 1'b1;
    repeat (4) begin
      at_neg();
      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_pc_ready", 64'(pc_ready), 64'd0);
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      cyc();
    end
    reset = 1'b1; pc_valid = 1'b0; imem_gnt = 1'b0;
    at_neg();
    chk("rel_pc_ready", 64'(pc_ready), 64'd1);
    chk("rst_id_pc", 64'(id_pc), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    cyc();

    // Basic fetch, latency 3 from pc_valid to id_valid.
    id_ready = 1'b1; pc_in = 32'h5; pc_valid = 1'b1; imem_gnt = 1'b1;
    at_neg(); chk("basic_pc_ready", 64'(pc_ready), 64'd1); cyc();
    pc_valid = 1'b0;
    at_neg(); chk("basic_req", 64'(imem_req), 64'd1); chk("basic_addr", 64'(imem_addr), 64'h005); cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0004;
    at_neg(); chk("basic_early_valid", 64'(id_valid), 64'd0); cyc();
    imem_rvalid = 1'b0;
    at_neg();
    chk("basic_valid", 64'(id_valid), 64'd1);
    chk("basic_instr", 64'(id_instr), 64'h8C22_0004);
    chk("basic_pc", 64'(id_pc), 64'h5);
    cyc();
    at_neg(); chk("basic_popped", 64'(id_valid), 64'd0); chk("basic_hold", 64'(id_instr), 64'h8C22_0004);
    cyc();

    // Backpressure: only DEPTH entries may be fetched ahead of decode.
    id_ready = 1'b0;
    fetch_one(32'd0, 32'hA000_0000);
    fetch_one(32'd1, 32'hA000_0001);
    pc_in = 32'd2; pc_valid = 1'b1;
    repeat (3) begin
      at_neg();
      chk("bp_pc_ready", 64'(pc_ready), 64'd0);
      chk("bp_req", 64'(imem_req), 64'd0);
      chk("bp_head", 64'(id_pc), 64'd0);
      cyc();
    end
    id_ready = 1'b1;
    at_neg(); chk("bp_out0", 64'(id_pc), 64'd0); chk("bp_full", 64'(pc_ready), 64'd0); cyc();
    at_neg(); chk("bp_out1", 64'(id_pc), 64'd1); chk("bp_resume", 64'(pc_ready), 64'd1); cyc();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    at_neg(); chk("bp_req2", 64'(imem_req), 64'd1); chk("bp_addr2", 64'(imem_addr), 64'd2); cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0002;
    cyc();
    imem_rvalid = 1'b0;
    at_neg(); chk("bp_pc2", 64'(id_pc), 64'd2); chk("bp_instr2", 64'(id_instr), 64'hA000_0002); cyc();
    fetch_one(32'd3, 32'hA000_0003);
    at_neg(); chk("bp_pc3", 64'(id_pc), 64'd3); cyc();

    // Stalled grant: request and address held; upper PC bits kept in id_pc.
    pc_in = 32'h0001_2ABC; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; imem_gnt = 1'b0;
    repeat (4) begin
      at_neg();
      chk("stall_req", 64'(imem_req), 64'd1);
      chk("stall_addr", 64'(imem_addr), 64'hABC);
      cyc();
    end
    imem_gnt = 1'b1;
    at_neg(); chk("stall_gnt_req", 64'(imem_req), 64'd1); cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    at_neg(); chk("stall_pc", 64'(id_pc), 64'h0001_2ABC); chk("stall_instr", 64'(id_instr), 64'h1234_5678); cyc();

    // Flush while waiting: the late response is dropped.
    pc_in = 32'h10; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; flush = 1'b1;
    at_neg(); chk("flw_pc_ready", 64'(pc_ready), 64'd0); cyc();
    flush = 1'b0;
    at_neg(); chk("flw_drain_ready", 64'(pc_ready), 64'd0); cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    at_neg();
    chk("flw_valid", 64'(id_valid), 64'd0);
    chk("flw_instr", 64'(id_instr), 64'h1234_5678);
    chk("flw_ready", 64'(pc_ready), 64'd1);
    cyc();
    fetch_one(32'h40, 32'h0040_0013);
    at_neg(); chk("flw_pc40", 64'(id_pc), 64'h40); chk("flw_instr40", 64'(id_instr), 64'h0040_0013); cyc();

    // Flush with coincident rvalid and pop while one entry is buffered.
    id_ready = 1'b0;
    fetch_one(32'h50, 32'h5050_5050);
    pc_in = 32'h60; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6060_6060; flush = 1'b1; id_ready = 1'b1;
    at_neg(); chk("flc_pre_valid", 64'(id_valid), 64'd1); cyc();
    imem_rvalid = 1'b0; flush = 1'b0; id_ready = 1'b0;
    at_neg();
    chk("flc_valid", 64'(id_valid), 64'd0);
    chk("flc_ready", 64'(pc_ready), 64'd1);
    chk("flc_req", 64'(imem_req), 64'd0);
    chk("flc_instr", 64'(id_instr), 64'h5050_5050);
    cyc();

    // Flush in REQ with coincident grant drains; without grant returns to idle.
    pc_in = 32'h70; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
    cyc();
    imem_gnt = 1'b0; flush = 1'b0;
    at_neg(); chk("flr_drain_ready", 64'(pc_ready), 64'd0); chk("flr_drain_req", 64'(imem_req), 64'd0); cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    cyc();
    imem_rvalid = 1'b0;
    at_neg(); chk("flr_idle_ready", 64'(pc_ready), 64'd1); chk("flr_valid", 64'(id_valid), 64'd0); cyc();
    pc_in = 32'h80; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    at_neg(); chk("flr_nogt_ready", 64'(pc_ready), 64'd1); chk("flr_nogt_req", 64'(imem_req), 64'd0); cyc();

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the pc block.
- Takes each fetch address produced by pc, issues a word read to instruction memory with a grant/response handshake, and buffers the returned instruction with its PC.
- Hands instruction and PC to decode with valid/ready flow control.
- Supports a flush (branch/jump redirect) that discards in-flight and buffered fetches.

Parameters:
- ADDR_W, 12, instruction-memory word-address width.
- DATA_W, 32, instruction width.
- DEPTH, 2, output buffer entries (power of two, >= 1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- pc_in  in  32  word-addressed fetch PC from pc block.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  fetch accepts pc_in this cycle.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word address of request.
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_W  read data.
- flush  in  1  discard all outstanding/buffered fetches.
- id_valid  out  1  id_instr/id_pc valid to decode.
- id_instr  out  DATA_W  fetched instruction.
- id_pc  out  32  PC of id_instr.
- id_ready  in  1  decode consumes the entry this cycle.

Behaviour:
- Reset: sampled on clock edge when reset==0; state<=IDLE, buffer count<=0, req_pc<=0. Reset values: imem_req=0, imem_addr=0, pc_ready=0, id_valid=0, id_instr=0, id_pc=0. Reset mid-transaction drops any pending response, with no DRAIN state.
- Credit: credit = (count + (state!=IDLE)) < DEPTH. This bounds the design to one outstanding request; the buffer never overflows.
- pc_ready = (state==IDLE) & credit & ~flush & reset. This is combinational.
- Accept: on pc_valid & pc_ready, req_pc<=pc_in and state<=REQ.
- imem_addr = req_pc[ADDR_W-1:0]. Bits 31:ADDR_W are ignored for addressing but kept in id_pc.
- REQ: imem_req=1; imem_addr is held stable until imem_gnt. On gnt, state<=WAIT. The request is withdrawn only by flush.
- WAIT: on imem_rvalid, push {imem_rdata, req_pc} into the buffer and set state<=IDLE. rvalid outside WAIT/DRAIN is ignored.
- DRAIN: wait for imem_rvalid, discard the data, then set state<=IDLE.
- Latency: pc_valid at cycle 0 gives imem_req at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, id_valid rises at cycle 3.
- Throughput: at most one fetch per 3 cycles with single-cycle memory.
- Output: id_valid = (count!=0). id_instr/id_pc come from the buffer head (registered, no combinational path from imem_rdata). On id_valid & id_ready, the head is popped. Push and pop may happen in the same cycle; count is then unchanged.
- Empty buffer: id_instr/id_pc hold their last value, and id_valid=0.
- Flush takes priority over everything in the same cycle:
  - count<=0 and id_valid=0 next cycle; a coincident pop or push is discarded.
  - IDLE or REQ without gnt: state<=IDLE.
  - REQ with gnt in same cycle: state<=DRAIN.
  - WAIT without rvalid: state<=DRAIN.
  - WAIT with rvalid: data discarded, state<=IDLE.
  - DRAIN: stays DRAIN unless rvalid arrives.
  - pc_ready is forced 0 during flush.
- Buffer pointers wrap modulo DEPTH.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, WAIT, DRAIN};
  - default ADDR_W/DATA_W constants;
  - fetch entry struct {instr, pc}.
- One sub-module, fetch_buffer: a synchronous DEPTH-entry FIFO of fetch entries, with push, pop, clear, count and registered head outputs.
- The FSM and credit logic live in fetch_stage.

Test Plan:
- Reset: hold reset=0 with pc_valid=1 and imem_gnt=1 -> all outputs 0 and imem_req never asserted. Release reset -> pc_ready=1 in the next cycle.
- Basic fetch: pc_in=0x00000005, single-cycle gnt, rvalid the next cycle with rdata=0x8C220004, id_ready=1 -> imem_addr=0x005, id_valid at cycle 3, id_instr=0x8C220004, id_pc=0x5.
- Backpressure: id_ready=0 and sequential PCs 0..3 -> exactly 2 entries buffered, pc_ready=0 afterwards, no imem_req. Raise id_ready -> entries 0,1 out in order, then fetches resume at 2.
- Stalled grant: imem_gnt low for 4 cycles -> imem_req stays 1 and imem_addr stays constant. Then gnt -> WAIT, and normal completion follows.
- Flush in WAIT: flush while waiting for PC 0x10, rvalid 2 cycles later with 0xDEADBEEF -> data never appears on id_*. Next accepted PC 0x40 returns its own data correctly.
- Flush with coincident rvalid and pop, buffer holding 1 entry -> id_valid=0 next cycle, count=0, state IDLE, pc_ready=1 the cycle after flush deasserts.
